// File: rtl/ss_wb_pkg.sv
// ss_wb_pkg: shared FSM state, response codes and bus widths for the 64-bit split-data Wishbone slave
package ss_wb_pkg;
  localparam int LANE_W = 32;
  localparam int WORD_W = 64;
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_BEAT = 3'd1, S_RTY = 3'd2, S_ERR = 3'd3} state_t;
  localparam logic [2:0] RSP_ACK  = 3'b100;
  localparam logic [2:0] RSP_RTY  = 3'b010;
  localparam logic [2:0] RSP_ERR  = 3'b001;
  localparam logic [2:0] RSP_NONE = 3'b000;
endpackage

// File: rtl/ss_wb_slv_if.sv
// ss_wb_slv_if: 64-bit split-data Wishbone bus (32+32 data lanes) between a master and ss_wb_slv
interface ss_wb_slv_if;
  import ss_wb_pkg::*;
  logic              wbs_cyc, wbs_stb, wbs_we, wbs_cab;
  logic [3:0]        wbs_sel;
  logic [31:0]       wbs_adr;
  logic [LANE_W-1:0] wbs_dat_i, wbs_dat64_i, wbs_dat_o, wbs_dat64_o;
  logic              wbs_ack, wbs_rty, wbs_err;
  modport master (
    output wbs_cyc, wbs_stb, wbs_we, wbs_cab, wbs_sel, wbs_adr, wbs_dat_i, wbs_dat64_i,
    input  wbs_dat_o, wbs_dat64_o, wbs_ack, wbs_rty, wbs_err
  );
  modport slave (
    input  wbs_cyc, wbs_stb, wbs_we, wbs_cab, wbs_sel, wbs_adr, wbs_dat_i, wbs_dat64_i,
    output wbs_dat_o, wbs_dat64_o, wbs_ack, wbs_rty, wbs_err
  );
endinterface

// File: rtl/ss_wb_ram.sv
// ss_wb_ram: single-port 64-bit synchronous RAM, high-word enable plus per-byte low-word enables, registered read
module ss_wb_ram
  import ss_wb_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic              we_hi,
  input  logic [3:0]        we_lo,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wd,
  output logic [WORD_W-1:0] q
);
  logic [WORD_W-1:0] mem [DEPTH];
  // write the high word and each enabled low-word byte
  always_ff @(posedge clk) begin
    if (we_hi) mem[addr][WORD_W-1:LANE_W] <= wd[WORD_W-1:LANE_W];
    for (int i = 0; i < 4; i++)
      if (we_lo[i]) mem[addr][8*i +: 8] <= wd[8*i +: 8];
  end
  // registered read; cleared on reset so the bus data outputs start at zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (re) q <= mem[addr];
endmodule

// File: rtl/ss_wb_slv.sv
// ss_wb_slv: Wishbone burst slave over a 64-bit word memory; window check and burst-end err under SS_WB_SLV_ERR_EN
module ss_wb_slv
  import ss_wb_pkg::*;
#(
  parameter int          DEPTH = 512,
  parameter int          AW    = 9,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  ss_wb_slv_if.slave  wbs,
  input  logic        slv_hold,
  output logic [15:0] slv_acks
);
  state_t state, state_nx;
  logic [AW-1:0] ptr, wr_adr;
  logic [2:0] rsp, rsp_nx;
  logic req, in_win, wrap_err, wr, full, unused;
  logic [WORD_W-1:0] q;
  assign req  = wbs.wbs_cyc & wbs.wbs_stb;
  assign wr   = rsp[2] & req & wbs.wbs_we;
  assign full = wbs.wbs_sel == 4'h0 || wbs.wbs_sel == 4'hF;
  assign wbs.wbs_ack = rsp[2];
  assign wbs.wbs_rty = rsp[1];
  assign {wbs.wbs_dat64_o, wbs.wbs_dat_o} = q;
`ifdef SS_WB_SLV_ERR_EN
  assign in_win      = wbs.wbs_adr[31:AW+3] == BASE[31:AW+3];
  assign wrap_err    = &ptr;
  assign wbs.wbs_err = rsp[0];
  assign unused      = ^wbs.wbs_adr[2:0];
`else
  assign in_win      = 1'b1;
  assign wrap_err    = 1'b0;
  assign wbs.wbs_err = 1'b0;
  assign unused      = ^{BASE, wbs.wbs_adr[31:AW+3], wbs.wbs_adr[2:0], rsp[0]};
`endif
  // next state and the response presented in the following cycle; a new strobe waits until the last response is gone
  always_comb begin
    state_nx = S_IDLE;
    rsp_nx   = RSP_NONE;
    if (wbs.wbs_cyc)
      case (state)
        S_IDLE: state_nx = !req || rsp != RSP_NONE ? S_IDLE : !in_win ? S_ERR : slv_hold ? S_RTY : S_BEAT;
        S_BEAT: begin
          rsp_nx   = RSP_ACK;
          state_nx = !(wbs.wbs_stb && wbs.wbs_cab) ? S_IDLE : wrap_err ? S_ERR : slv_hold ? S_RTY : S_BEAT;
        end
        S_RTY:  rsp_nx = RSP_RTY;
        S_ERR:  rsp_nx = RSP_ERR;
        default: ;
      endcase
  end
  // state, burst pointer, write address of the beat being acked, registered responses and ack counter
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      state    <= S_IDLE;
      ptr      <= '0;
      wr_adr   <= '0;
      rsp      <= RSP_NONE;
      slv_acks <= '0;
    end else begin
      state    <= state_nx;
      rsp      <= rsp_nx;
      slv_acks <= slv_acks + 16'(rsp_nx[2]);
      ptr      <= state == S_IDLE && state_nx == S_BEAT ? wbs.wbs_adr[AW+2:3] : state == S_BEAT ? ptr + 1'b1 : ptr;
      wr_adr   <= state == S_BEAT ? ptr : wr_adr;
    end
  ss_wb_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .re    (!wr),
    .we_hi (wr & full),
    .we_lo (wr ? (full ? 4'hF : wbs.wbs_sel) : 4'h0),
    .addr  (wr ? wr_adr : ptr),
    .wd    ({wbs.wbs_dat64_i, wbs.wbs_dat_i}),
    .q     (q)
  );
endmodule

// File: tb/tb_ss_wb_slv.sv
// tb_ss_wb_slv: scoreboard bench for ss_wb_slv; window/err checks follow SS_WB_SLV_ERR_EN
module tb_ss_wb_slv;
  import ss_wb_pkg::*;
  typedef struct packed {logic [2:0] rsp; logic [63:0] dat; logic cd;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, hold = 1'b0;
  logic [15:0] slv_acks, exp_acks = '0;
  logic [63:0] mdl [512];
  exp_t exp_q[$];
  exp_t mon_e;
  int ack_cyc[$];
  int cyc_n = 0, n_cmp = 0, n_bad = 0;
  ss_wb_slv_if bus();
  ss_wb_slv #(.DEPTH(512), .AW(9), .BASE(32'h0)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wbs(bus), .slv_hold(hold), .slv_acks(slv_acks));
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [3:0] sel);
    merge = old;
    if (sel == 4'h0 || sel == 4'hF) merge = d;
    else for (int b = 0; b < 4; b++) if (sel[b]) merge[8*b +: 8] = d[8*b +: 8];
  endfunction
  always @(negedge clk)
    if (rst_n && (bus.wbs_ack || bus.wbs_rty || bus.wbs_err)) begin
      if (bus.wbs_ack) ack_cyc.push_back(cyc_n);
      if (exp_q.size() == 0) chk("unexpected_rsp", 64'({bus.wbs_ack, bus.wbs_rty, bus.wbs_err}), 64'(RSP_NONE));
      else begin
        mon_e = exp_q.pop_front();
        chk("rsp", 64'({bus.wbs_ack, bus.wbs_rty, bus.wbs_err}), 64'(mon_e.rsp));
        if (mon_e.cd) chk("rdata", {bus.wbs_dat64_o, bus.wbs_dat_o}, mon_e.dat);
      end
    end
  task automatic idle_bus();
    bus.wbs_cyc = 0; bus.wbs_stb = 0; bus.wbs_cab = 0; bus.wbs_we = 0;
    bus.wbs_sel = 4'h0; bus.wbs_adr = '0; bus.wbs_dat_i = '0; bus.wbs_dat64_i = '0; hold = 0;
  endtask
  // one transfer of n beats; hold_c is the cycle (0 = strobe cycle) from which slv_hold is raised, -1 for none
  task automatic xfer(input logic [31:0] adr, input int n, input logic we, input logic [3:0] sel,
                      input logic [63:0] d0, input int hold_c);
    int acks, r;
    logic [2:0] term;
    logic [8:0] w;
    logic [63:0] d;
    w = adr[11:3]; acks = n; term = RSP_NONE;
`ifdef SS_WB_SLV_ERR_EN
    if (adr[31:12] != 20'h0) begin acks = 0; term = RSP_ERR; end
    else if (n > 512 - int'(w)) begin acks = 512 - int'(w); term = RSP_ERR; end
`endif
    if (term == RSP_NONE && hold_c >= 0 && hold_c < n) begin acks = hold_c; term = RSP_RTY; end
    for (int k = 0; k < acks; k++) begin
      d = d0 + 64'(k);
      if (we) begin
        mdl[w] = merge(mdl[w], d, sel);
        exp_q.push_back('{RSP_ACK, 64'h0, 1'b0});
      end else exp_q.push_back('{RSP_ACK, mdl[w], 1'b1});
      w = w + 9'd1;
    end
    if (term != RSP_NONE) exp_q.push_back('{term, 64'h0, 1'b0});
    exp_acks += 16'(acks);
    r = acks + ((term != RSP_NONE) ? 1 : 0);
    ack_cyc.delete();
    for (int c = 0; c <= r + 2; c++) begin
      bus.wbs_cyc = c < r + 2; bus.wbs_stb = c < r + 2; bus.wbs_cab = c < n;
      bus.wbs_we = we; bus.wbs_sel = sel; bus.wbs_adr = adr;
      hold = hold_c >= 0 && c >= hold_c;
      {bus.wbs_dat64_i, bus.wbs_dat_i} = d0 + 64'(c) - 64'd2;
      @(posedge clk); #1;
    end
    idle_bus();
    repeat (2) @(posedge clk);
    #1;
    chk("ack_count", 64'(ack_cyc.size()), 64'(acks));
    if (acks > 1) chk("ack_bubble", 64'(ack_cyc[$] - ack_cyc[0]), 64'(acks - 1));
    chk("slv_acks", 64'(slv_acks), 64'(exp_acks));
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask
  initial begin
    idle_bus();
    #12;
    chk("rst_ack", 64'(bus.wbs_ack), 64'd0);
    chk("rst_rty", 64'(bus.wbs_rty), 64'd0);
    chk("rst_err", 64'(bus.wbs_err), 64'd0);
    chk("rst_dat", {bus.wbs_dat64_o, bus.wbs_dat_o}, 64'd0);
    chk("rst_cnt", 64'(slv_acks), 64'd0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    xfer(32'h28, 1, 1, 4'hF, 64'h1122_3344_5566_7788, -1);
    xfer(32'h28, 1, 0, 4'h0, 64'h0, -1);
    xfer(32'h40, 4, 1, 4'h0, 64'd1, -1);
    xfer(32'h40, 4, 0, 4'h0, 64'h0, -1);
    xfer(32'h60, 1, 1, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, -1);
    xfer(32'h60, 1, 1, 4'h3, 64'h1234_5678_AAAA_BBBB, -1);
    xfer(32'h60, 1, 0, 4'h0, 64'h0, -1);
    xfer(32'h28, 1, 1, 4'hF, 64'hDEAD_BEEF_0000_0001, 0);
    xfer(32'h28, 1, 0, 4'h0, 64'h0, -1);
    xfer(32'h40, 4, 0, 4'h0, 64'h0, 2);
    xfer(32'h0, 1, 1, 4'hF, 64'hA0A0_A0A0_A0A0_A0A0, -1);
    xfer(32'h1000, 1, 1, 4'hF, 64'h0BAD_0BAD_0BAD_0BAD, 0);
    xfer(32'h0, 1, 0, 4'h0, 64'h0, -1);
    xfer(32'hFF0, 3, 1, 4'hF, 64'h7000, -1);
    xfer(32'hFF0, 2, 0, 4'h0, 64'h0, -1);
    xfer(32'h0, 1, 0, 4'h0, 64'h0, -1);
    xfer(32'hA0, 4, 1, 4'hF, 64'h5000, -1);
    ack_cyc.delete();
    exp_q.push_back('{RSP_ACK, 64'h0, 1'b0});
    mdl[20] = 64'h6000;
    bus.wbs_adr = 32'hA0; bus.wbs_we = 1; bus.wbs_sel = 4'hF;
    bus.wbs_cab = 1; bus.wbs_cyc = 1; bus.wbs_stb = 1;
    for (int c = 0; c < 4; c++) begin
      {bus.wbs_dat64_i, bus.wbs_dat_i} = 64'h6000 + 64'(c) - 64'd2;
      if (c < 3) begin @(posedge clk); #1; end
    end
    #2 rst_n = 0;
    #1;
    chk("midrst_ack", 64'(bus.wbs_ack), 64'd0);
    chk("midrst_rty", 64'(bus.wbs_rty), 64'd0);
    chk("midrst_err", 64'(bus.wbs_err), 64'd0);
    chk("midrst_dat", {bus.wbs_dat64_o, bus.wbs_dat_o}, 64'd0);
    chk("midrst_cnt", 64'(slv_acks), 64'd0);
    chk("midrst_acks_seen", 64'(ack_cyc.size()), 64'd1);
    idle_bus();
    exp_acks = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    xfer(32'hA0, 4, 0, 4'h0, 64'h0, -1);
    xfer(32'h28, 1, 0, 4'h0, 64'h0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ss_wb_slv.md
# ss_wb_slv

Wishbone slave responder for the 64-bit split-data bus driven by the scatter-gather engines: `wbs_dat*` 32+32 lanes with `cyc`/`stb`/`we`/`cab`/`sel` and `ack`/`rty`/`err` responses. It answers descriptor fetches and buffer reads and writes from an internal 64-bit word memory. It sustains `cab` bursts at one ack per cycle, inserts retries under a hold input, and flags out-of-window addresses with `err`. It serves as the on-chip descriptor/buffer target in system simulation and as the SRAM-backed target in the FPGA build.

## Interface
- `DEPTH`, 512: number of 64-bit words; power of two.
- `AW`, 9: log2(`DEPTH`).
- `BASE`, 32'h0000_0000: byte base address of the window; aligned to `DEPTH*8`.
- `wb_clk_i` in 1: the single clock.
- `wb_rst_n_i` in 1: reset, asynchronous, active-low.
- `wbs_cyc` in 1: bus cycle.
- `wbs_stb` in 1: strobe.
- `wbs_we` in 1: write enable.
- `wbs_cab` in 1: burst (consecutive address) cycle.
- `wbs_sel` in 4: byte select.
- `wbs_adr` in 32: byte address; bits [2:0] are ignored.
- `wbs_dat_i` in 32: write data, low word.
- `wbs_dat64_i` in 32: write data, high word.
- `wbs_dat_o` out 32: read data, low word.
- `wbs_dat64_o` out 32: read data, high word.
- `wbs_ack` out 1: acknowledge.
- `wbs_rty` out 1: retry.
- `wbs_err` out 1: error.
- `slv_hold` in 1: target not ready; forces `rty`.
- `slv_acks` out 16: count of acked beats, wraps at 2^16.

## Operation
- The memory word index is `wbs_adr[AW+2:3]`, taken from a burst pointer `ptr`.
- Writes:
  - `sel==4'h0` or `sel==4'hF` writes the full 64 bits (`dat64_i` is the high word, `dat_i` the low word).
  - Any other `sel` byte-enables the low word only; the high word is unchanged.
- Reads ignore `sel`.
- States:
  - **IDLE**: `cyc&stb` sampled.
    - Out of window → ERR.
    - Otherwise, `slv_hold` → RTY.
    - Otherwise, latch `ptr` and go to BEAT.
  - **BEAT**: assert `ack` with the data of `ptr` (a write commits this cycle) and increment `ptr`.
    - If `cyc&stb&cab` and not `slv_hold`, stay in BEAT.
    - If `cyc&stb&cab&slv_hold`, go to RTY.
    - Otherwise go to IDLE.
  - **RTY**: one-cycle `rty`, then IDLE. The master either drops `cyc` or re-strobes, which restarts with a fresh address latch.
  - **ERR**: one-cycle `err`, then IDLE. Nothing is written.
- In a burst, the address comes from `ptr` and not from `wbs_adr`, because the master's address lags the ack by a cycle. `ptr` wraps modulo `DEPTH`.
- Write data for beat k is sampled in the cycle the ack for beat k is asserted.
- When the master drops `cyc` after the last ack, the read prefetched for the next beat is discarded and has no side effects.
- `slv_acks` increments on every `ack` cycle.

## Timing
- Reset (async, `wb_rst_n_i`=0):
  - State is IDLE.
  - `ack`, `rty` and `err` are 0.
  - `dat_o` and `dat64_o` are 0.
  - `slv_acks` is 0; `ptr` is 0.
  - Memory contents are undefined.
- First-beat latency: `stb` sampled at edge N gives `ack`/`rty`/`err` high in the cycle after edge N+1 (one wait state). Read data is valid in the same cycle as `ack`.
- A burst delivers back-to-back acks with no bubbles while `cab` is held and `slv_hold` is low.
- `ack`, `rty` and `err` are mutually exclusive. All outputs are registered.
- `cyc` deasserted in any state: the next state is IDLE, with no response in that cycle.
- Reset asserted mid-burst: outputs clear immediately. A write that has not yet been acked is not committed.
- Simultaneous `slv_hold` and an out-of-window address: `err` wins.

## Configuration
- `SS_WB_SLV_ERR_EN` defined:
  - Addresses outside [`BASE`, `BASE`+`DEPTH*8`) give ERR.
  - A burst whose `ptr` would pass the window end terminates with `err` instead of `ack`.
- Undefined:
  - No window check; `wbs_err` is tied 0.
  - Addresses alias modulo `DEPTH` and `ptr` wraps silently.

## Structure
- Shared package `ss_wb_pkg`:
  - State encoding (IDLE/BEAT/RTY/ERR, 3 bits).
  - Response codes `{ack,rty,err}` = 3'b100, 3'b010, 3'b001.
  - Bus width constants (32 per lane, 64 per word).
- Sub-module `ss_wb_ram`:
  - Single-port synchronous 64-bit RAM, `DEPTH` words.
  - Separate enables for the high word and for each low-word byte.
  - One-cycle registered read.
- The parent holds the FSM, `ptr`, the window check and the counter.

## Test plan
- Single read: preload word 5 = 64'h1122_3344_5566_7788; `adr`=32'h28, `cab`=0 → one `ack`, `dat64_o`=32'h1122_3344, `dat_o`=32'h5566_7788, `slv_acks`=1.
- Burst write then read: `cab`=1, 4 beats from `adr`=32'h40, `sel`=4'h0, data 1..4 → 4 consecutive acks with no bubble. Reading back words 8..11 returns 1..4.
- Partial write: `sel`=4'h3 with `dat_i`=32'hAAAA_BBBB to a word holding all F's → word becomes 64'hFFFF_FFFF_FFFF_BBBB.
- Retry: `slv_hold`=1 at the strobe → single `rty`, no memory change. With `slv_hold` asserted on beat 3 of a burst → 2 acks, then `rty`.
- Error (`SS_WB_SLV_ERR_EN`): `adr`=`BASE`+`DEPTH*8` → single `err`, memory unchanged, `slv_acks` unchanged. Without the macro, the same access aliases to word 0 and is acked.
- Reset mid-burst: drop `wb_rst_n_i` on beat 2 → all outputs 0 in the same cycle. After release, a new single read completes normally.
